// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller and the lamp decoders.
// Lamp codes are the 2-bit values driven per phase; state_e is the controller FSM state.
package traffic_pkg;

  localparam logic [1:0] LampRed    = 2'b00;
  localparam logic [1:0] LampYellow = 2'b01;
  localparam logic [1:0] LampGreen  = 2'b10;
  localparam logic [1:0] LampOff    = 2'b11;

  typedef enum logic [1:0] {
    StDark,
    StAllRed,
    StGreen,
    StYellow
  } state_e;

endpackage

// File: rtl/sec_prescaler.sv
// Seconds prescaler: counts 0..CLK_HZ-1 and flags the last count of each second.
// Ports:
//   clk     - system clock
//   reset   - synchronous, active-high; count returns to 0
//   restart - synchronous; count returns to 0 on the next edge (state entry)
//   tick    - high during the cycle where the count equals CLK_HZ-1
module sec_prescaler #(
  parameter int unsigned CLK_HZ = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase intersection controller: ALL_RED -> GREEN -> YELLOW per phase, with latched
// sensor requests that skip idle phases and extend an uncontested green.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   enable       - low forces DARK (all lamps OFF)
//   req          - synchronised level request per phase
//   phase_light  - 2-bit lamp code per phase, phase i at [2i+1:2i]
//   ped_walk     - walk signal for the crossing parallel to each phase
//   active_phase - index of the phase currently served
//   secs_left    - whole seconds remaining in the current state, minus 1
//   sec_tick     - one-cycle pulse at each second boundary
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 10000,
  parameter int unsigned N_PHASES     = 3,
  parameter int unsigned SEC_W        = 8,
  parameter int unsigned ALLRED_S     = 1,
  parameter int unsigned YELLOW_S     = 3,
  parameter int unsigned GREEN_BASE_S = 27,
  parameter int unsigned GREEN_EXT_S  = 27,
  localparam int unsigned PhW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_PHASES-1:0]   req,
  output logic [2*N_PHASES-1:0] phase_light,
  output logic [N_PHASES-1:0]   ped_walk,
  output logic [PhW-1:0]        active_phase,
  output logic [SEC_W-1:0]      secs_left,
  output logic                  sec_tick
);

  typedef logic [PhW-1:0] phase_t;

  localparam logic [SEC_W-1:0] AllRedLoad = SEC_W'(ALLRED_S - 1);
  localparam logic [SEC_W-1:0] YellowLoad = SEC_W'(YELLOW_S - 1);
  localparam logic [SEC_W-1:0] BaseLoad   = SEC_W'(GREEN_BASE_S - 1);
  localparam logic [SEC_W-1:0] LongLoad   = SEC_W'(GREEN_BASE_S + GREEN_EXT_S - 1);

  // First pending phase after cur, round-robin, with cur itself considered last.
  // Scanning from the farthest offset down lets the nearest pending phase win.
  function automatic phase_t next_phase(phase_t cur, logic [N_PHASES-1:0] pend);
    phase_t      res;
    int unsigned idx;
    res = phase_t'((32'(cur) + 1) % N_PHASES);
    for (int unsigned k = N_PHASES; k >= 1; k--) begin
      idx = (32'(cur) + k) % N_PHASES;
      if (pend[phase_t'(idx)]) res = phase_t'(idx);
    end
    return res;
  endfunction

  function automatic logic [2*N_PHASES-1:0] lamps(state_e st, phase_t act);
    logic [2*N_PHASES-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_PHASES; i++) begin
      case (st)
        StDark:   r[2*i +: 2] = LampOff;
        StGreen:  if (phase_t'(i) == act) r[2*i +: 2] = LampGreen;
        StYellow: if (phase_t'(i) == act) r[2*i +: 2] = LampYellow;
        default:  r[2*i +: 2] = LampRed;
      endcase
    end
    return r;
  endfunction

  state_e                state_q, state_d;
  phase_t                active_q, active_d;
  logic [N_PHASES-1:0]   pending_q, pending_d;
  logic [N_PHASES-1:0]   others;
  logic [SEC_W-1:0]      secs_q, secs_d;
  logic [2*N_PHASES-1:0] light_q;
  logic [N_PHASES-1:0]   ped_q, ped_d;
  logic                  tick;
  logic                  restart;

  sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
    secs_d    = secs_q;
    others    = pending_q;
    others[active_q] = 1'b0;

    if (!enable) begin
      state_d = StDark;
    end else if (state_q == StDark) begin
      state_d  = StAllRed;
      active_d = '0;
      secs_d   = AllRedLoad;
    end else begin
      pending_d = pending_q | req;
      if (tick) begin
        if (secs_q == '0) begin
          case (state_q)
            StAllRed: begin
              state_d = StGreen;
              secs_d  = (others == '0) ? LongLoad : BaseLoad;
              // Entering green consumes this phase's request; a req still high in
              // green re-latches it on the following cycle.
              pending_d[active_q] = 1'b0;
            end
            StGreen: begin
              state_d = StYellow;
              secs_d  = YellowLoad;
            end
            StYellow: begin
              state_d  = StAllRed;
              secs_d   = AllRedLoad;
              active_d = next_phase(active_q, pending_q);
            end
            default: ;
          endcase
        end else begin
          secs_d = secs_q - SEC_W'(1);
        end
      end
    end

    ped_d = '0;
    if (state_d == StGreen) ped_d[active_d] = 1'b1;
  end

  assign restart = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StAllRed;
      active_q  <= '0;
      pending_q <= '0;
      secs_q    <= AllRedLoad;
      light_q   <= '0;
      ped_q     <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      secs_q    <= secs_d;
      light_q   <= lamps(state_d, active_d);
      ped_q     <= ped_d;
    end
  end

  assign phase_light  = light_q;
  assign ped_walk     = ped_q;
  assign active_phase = active_q;
  assign secs_left    = secs_q;
  assign sec_tick     = tick;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed self-checking bench for traffic_phase_ctrl (CLK_HZ=10, N_PHASES=3).
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [2:0] req = 3'b000;
  logic [5:0] phase_light;
  logic [2:0] ped_walk;
  logic [1:0] active_phase;
  logic [7:0] secs_left;
  logic       sec_tick;

  int checks = 0;
  int errors = 0;

  traffic_phase_ctrl #(
    .CLK_HZ  (10),
    .N_PHASES(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .phase_light (phase_light),
    .ped_walk    (ped_walk),
    .active_phase(active_phase),
    .secs_left   (secs_left),
    .sec_tick    (sec_tick)
  );

  always #5 clk = ~clk;

  // Leaves the bench at the negedge of the first post-reset cycle (prescaler 0).
  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b1;
    req = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Number of consecutive cycles, starting now, with unchanged lamps/walk/phase.
  task automatic measure(output int n);
    logic [10:0] ref_v;
    bit          done;
    ref_v = {phase_light, ped_walk, active_phase};
    n = 1;
    done = 1'b0;
    while (!done && n < 2000) begin
      @(negedge clk);
      if ({phase_light, ped_walk, active_phase} !== ref_v) done = 1'b1;
      else n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL measure_timeout got %0d cycles without change want a change", n);
    end
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    checks++;
    if ({phase_light, ped_walk, active_phase, secs_left, sec_tick} !== 20'd0) begin
      errors++;
      $display("FAIL reset_values got light=%b walk=%b ph=%0d secs=%0d tick=%b want all zero",
               phase_light, ped_walk, active_phase, secs_left, sec_tick);
    end
    measure(n);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL allred_len got %0d want 10", n); end
    checks++;
    if ({phase_light, ped_walk, active_phase} !== {6'b000010, 3'b001, 2'd0}) begin
      errors++;
      $display("FAIL green0_lamps got %b/%b/%0d want 000010/001/0",
               phase_light, ped_walk, active_phase);
    end
    checks++;
    if (secs_left !== 8'd53) begin
      errors++; $display("FAIL green0_secs got %0d want 53", secs_left);
    end
    measure(n);
    checks++;
    if (n !== 540) begin errors++; $display("FAIL green0_len got %0d want 540", n); end
    checks++;
    if ({phase_light, ped_walk} !== {6'b000001, 3'b000}) begin
      errors++; $display("FAIL yellow0_lamps got %b/%b want 000001/000", phase_light, ped_walk);
    end
    measure(n);
    checks++;
    if (n !== 30) begin errors++; $display("FAIL yellow0_len got %0d want 30", n); end
    checks++;
    if ({phase_light, active_phase} !== {6'b000000, 2'd1}) begin
      errors++; $display("FAIL allred1 got %b/%0d want 000000/1", phase_light, active_phase);
    end
    measure(n);
    checks++;
    if ({phase_light, ped_walk, active_phase} !== {6'b001000, 3'b010, 2'd1}) begin
      errors++; $display("FAIL green1_lamps got %b/%b/%0d want 001000/010/1",
                         phase_light, ped_walk, active_phase);
    end
    measure(n);
    checks++;
    if (n !== 540) begin errors++; $display("FAIL green1_len got %0d want 540", n); end
    measure(n);
    measure(n);
    checks++;
    if ({phase_light, ped_walk, active_phase} !== {6'b100000, 3'b100, 2'd2}) begin
      errors++; $display("FAIL green2_lamps got %b/%b/%0d want 100000/100/2",
                         phase_light, ped_walk, active_phase);
    end
    measure(n);
    measure(n);
    measure(n);
    checks++;
    if ({phase_light, active_phase} !== {6'b000010, 2'd0}) begin
      errors++; $display("FAIL wrap_green0 got %b/%0d want 000010/0", phase_light, active_phase);
    end
  endtask

  task automatic test_pulse_in_green();
    int n;
    do_reset();
    measure(n);
    req = 3'b100;
    @(negedge clk);
    req = 3'b000;
    measure(n);
    checks++;
    if (n + 1 !== 540) begin
      errors++; $display("FAIL pulse_green_len got %0d want 540", n + 1);
    end
    measure(n);
    measure(n);
    checks++;
    if ({phase_light, ped_walk, active_phase} !== {6'b100000, 3'b100, 2'd2}) begin
      errors++; $display("FAIL pulse_skip got %b/%b/%0d want 100000/100/2",
                         phase_light, ped_walk, active_phase);
    end
    measure(n);
    checks++;
    if (n !== 540) begin errors++; $display("FAIL pulse_green2_len got %0d want 540", n); end
  endtask

  task automatic test_two_requests();
    int n;
    int bad_secs;
    int ticks;
    do_reset();
    req = 3'b110;
    measure(n);
    req = 3'b000;
    bad_secs = 0;
    ticks = 0;
    for (int k = 0; k < 270; k++) begin
      if (secs_left !== 8'(26 - k / 10)) bad_secs++;
      if (sec_tick !== ((k % 10) == 9)) bad_secs++;
      if (sec_tick === 1'b1) ticks++;
      @(negedge clk);
    end
    checks++;
    if (bad_secs !== 0) begin
      errors++; $display("FAIL secs_tick_profile got %0d bad samples want 0", bad_secs);
    end
    checks++;
    if (ticks !== 27) begin errors++; $display("FAIL tick_count got %0d want 27", ticks); end
    checks++;
    if (phase_light !== 6'b000001) begin
      errors++; $display("FAIL base_green0_end got %b want 000001", phase_light);
    end
    measure(n);
    measure(n);
    checks++;
    if ({phase_light, active_phase} !== {6'b001000, 2'd1}) begin
      errors++; $display("FAIL two_req_ph1 got %b/%0d want 001000/1", phase_light, active_phase);
    end
    measure(n);
    checks++;
    if (n !== 270) begin errors++; $display("FAIL two_req_green1_len got %0d want 270", n); end
    measure(n);
    measure(n);
    checks++;
    if ({phase_light, active_phase} !== {6'b100000, 2'd2}) begin
      errors++; $display("FAIL two_req_ph2 got %b/%0d want 100000/2", phase_light, active_phase);
    end
    measure(n);
    checks++;
    if (n !== 540) begin errors++; $display("FAIL two_req_green2_len got %0d want 540", n); end
  endtask

  task automatic test_enable();
    int n;
    do_reset();
    measure(n);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({phase_light, ped_walk} !== {6'b111111, 3'b000}) begin
      errors++; $display("FAIL dark got %b/%b want 111111/000", phase_light, ped_walk);
    end
    repeat (7) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if ({phase_light, ped_walk, active_phase, secs_left} !== {6'b0, 3'b0, 2'd0, 8'd0}) begin
      errors++; $display("FAIL reenable got %b/%b/%0d/%0d want 000000/000/0/0",
                         phase_light, ped_walk, active_phase, secs_left);
    end
    measure(n);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL reenable_allred_len got %0d want 10", n); end
  endtask

  task automatic test_reset_in_yellow();
    int n;
    do_reset();
    measure(n);
    req = 3'b110;
    @(negedge clk);
    req = 3'b000;
    measure(n);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({phase_light, ped_walk, active_phase, secs_left, sec_tick} !== 20'd0) begin
      errors++; $display("FAIL reset_yellow got %b/%b/%0d/%0d/%b want all zero",
                         phase_light, ped_walk, active_phase, secs_left, sec_tick);
    end
    measure(n);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL reset_allred_len got %0d want 10", n); end
    measure(n);
    // A surviving pending vector would shorten this green to 270.
    checks++;
    if (n !== 540) begin errors++; $display("FAIL pending_cleared got %0d want 540", n); end
  endtask

  initial begin
    test_reset();
    test_pulse_in_green();
    test_two_requests();
    test_enable();
    test_reset_in_yellow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
